dm_responder: RTL and testbench
===============================

# dm_responder

Data-memory responder: the memory-side end of the data-memory interface driven by the pipeline's MEM stage. It accepts chip-select, active-low byte write-enables, a word address and write data. It commits byte-masked writes and returns read data with one cycle of synchronous latency. A parameterised wait-state counter emulates slower memory and raises a stall flag so the pipeline can hold its request.

## Interface
Parameters:
- ADDR_W, 14, word-address width; depth = 2**ADDR_W 32-bit words
- WAIT_CYCLES, 0, extra wait states per access (0..7)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- CS  in  1  access request, sampled on rising edge
- WEB  in  4  active-low byte write enables; 4'b1111 = read, any 0 bit = write of those lanes
- A  in  ADDR_W  word address
- DI  in  32  write data; lane i = DI[8i+7:8i]
- DO  out  32  read data, registered
- DM_stall  out  1  high while an accepted access is in wait states; registered

## Operation
- Reset (rst low) forces:
  - DO = 0, DM_stall = 0, state DM_IDLE, wait counter = 0.
  - Storage contents are not reset.
  - Any in-flight access is abandoned; no write commits.
- DM_IDLE, CS=1 sampled (DM_stall is always low in DM_IDLE): the request (WEB, A, DI) is accepted and latched.
  - WAIT_CYCLES=0: the access commits at the same edge; the state stays DM_IDLE.
  - WAIT_CYCLES=N>0: go to DM_WAIT, counter = N-1, DM_stall = 1.
- DM_WAIT: the counter decrements each edge. At the edge where the counter is 0, the latched access commits, the state returns to DM_IDLE and DM_stall = 0. CS/WEB/A/DI are ignored throughout DM_WAIT; the requester must hold its request until DM_stall falls.
- Commit, write: for each i with WEB[i]=0, mem[A] byte i = DI lane i. Other bytes are unchanged. DO holds its previous value.
- Commit, read (WEB=4'b1111): DO = mem[A].
- DO holds the last read value until the next read commits.
- A is a full-width word index, so no address can fall out of range.
- CS=0 in DM_IDLE: no state change.

## Timing
- An access accepted at edge k commits at edge k+N (N = WAIT_CYCLES). Read data is visible on DO after edge k+N.
- DM_stall is high from after edge k until edge k+N, i.e. for exactly N cycles. It is never high when N=0.
- N=0: back-to-back accesses every cycle. A read at edge k+1 to the address written at edge k returns the new data.
- N>0: the next acceptance is possible at edge k+N+1 at the earliest.
- Reset asserted during DM_WAIT: DM_stall drops asynchronously and the latched write is discarded.

## Structure
- Package dm_pkg holds:
  - WORD_W=32, BYTES=4, WEB_READ=4'b1111
  - typedef enum logic {DM_IDLE, DM_WAIT} dm_state_e
- Sub-module dm_byte_array holds the 2**ADDR_W x 32 storage with per-byte write enable and a registered read port. The top level contains the FSM, the wait counter and the request latch.

## Test plan
- N=0: write A=5, WEB=0000, DI=32'hDEADBEEF, then read A=5 on the next cycle -> DO=32'hDEADBEEF one edge later; DM_stall stays 0.
- N=0: after the above, write A=5, WEB=1110, DI=32'h000000AA, then read -> DO=32'hDEADBEAA.
- N=0: after writing A=5, write A=9 with DI=1 -> DO still 32'hDEADBEAA (writes do not update DO).
- N=3: read A=5 accepted at edge k -> DM_stall high for 3 cycles; DO=32'hDEADBEAA after edge k+3. Requests changed mid-wait to A=9 are ignored.
- N=3: write A=7, WEB=0000, DI=32'h12345678; assert rst one cycle after acceptance -> DO=0, DM_stall=0 immediately. A later read of A=7 does not return 32'h12345678.
- N=0: CS toggles with alternating read/write every cycle over 64 random addresses -> DO matches the reference model each cycle.

Source files
------------

// File: rtl/dm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dm_pkg                                                    |
// | Purpose  : Shared constants and types for the data-memory responder. |
// |            WORD_W   - data word width                                |
// |            BYTES    - byte lanes per word                            |
// |            WEB_READ - write-enable pattern that means "read"         |
// |            dm_state_e - responder FSM states                         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package dm_pkg;

  localparam int         WORD_W   = 32;
  localparam int         BYTES    = 4;
  localparam logic [3:0] WEB_READ = 4'b1111;

  typedef enum logic {
    DM_IDLE = 1'b0,
    DM_WAIT = 1'b1
  } dm_state_e;

endpackage
`default_nettype wire

// File: rtl/dm_byte_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dm_byte_array                                             |
// | Purpose  : 2**ADDR_W x 32-bit storage, one 8-bit array per lane,     |
// |            per-lane write enable and a registered read port.         |
// | Ports    : clk   - clock                                             |
// |            rst   - asynchronous active-low reset (read reg only)     |
// |            we    - active-high lane write enables                    |
// |            re    - read strobe, loads rdata from addr                |
// |            addr  - word address                                      |
// |            wdata - write data                                        |
// |            rdata - registered read data                              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module dm_byte_array
  import dm_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTES-1:0]  we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int c_DEPTH = 2 ** ADDR_W;

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    logic [7:0] r_mem [c_DEPTH];
    logic [7:0] r_rd;

    // Storage is never cleared; the reset term only blocks writes while
    // reset is held so an abandoned access cannot land in the array.
    always_ff @(posedge clk or negedge rst) begin
      if (rst && we[gi]) begin
        r_mem[addr] <= wdata[8*gi +: 8];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_rd <= 8'h00;
      end else if (re) begin
        r_rd <= r_mem[addr];
      end
    end

    assign rdata[8*gi +: 8] = r_rd;
  end

endmodule
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dm_responder                                              |
// | Purpose  : Memory-side end of the pipeline data-memory interface.    |
// |            Byte-masked writes, one-cycle registered reads, and an    |
// |            optional WAIT_CYCLES wait-state emulation with a stall.   |
// | Ports    : clk      - clock                                          |
// |            rst      - asynchronous active-low reset                  |
// |            CS       - access request                                 |
// |            WEB      - active-low byte write enables (1111 = read)    |
// |            A        - word address                                   |
// |            DI       - write data                                     |
// |            DO       - registered read data                           |
// |            DM_stall - high while an accepted access is waiting       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CS,
  input  logic [BYTES-1:0]  WEB,
  input  logic [ADDR_W-1:0] A,
  input  logic [WORD_W-1:0] DI,
  output logic [WORD_W-1:0] DO,
  output logic              DM_stall
);

  localparam int              c_CNT_W    = 3;
  localparam logic [c_CNT_W-1:0] c_CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : c_CNT_W'(WAIT_CYCLES - 1);

  dm_state_e          r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic               r_stall, w_stall_nxt;
  logic               w_accept;

  logic [BYTES-1:0]   w_we;
  logic               w_re;
  logic [ADDR_W-1:0]  w_addr;
  logic [WORD_W-1:0]  w_wdata;

  assign w_accept = (r_state == DM_IDLE) && CS;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= DM_IDLE;
      r_cnt   <= '0;
      r_stall <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stall <= w_stall_nxt;
    end
  end

  // The stall flag is registered alongside the state so it is high for
  // exactly the cycles the FSM spends in DM_WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall_nxt = 1'b0;
    case (r_state)
      DM_IDLE: begin
        if (CS && (WAIT_CYCLES != 0)) begin
          w_state_nxt = DM_WAIT;
          w_cnt_nxt   = c_CNT_INIT;
          w_stall_nxt = 1'b1;
        end
      end
      DM_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = DM_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt - 1'b1;
          w_stall_nxt = 1'b1;
        end
      end
      default: w_state_nxt = DM_IDLE;
    endcase
  end

  if (WAIT_CYCLES == 0) begin : g_no_wait
    // Zero wait states: the live request commits at the accepting edge.
    assign w_addr  = A;
    assign w_wdata = DI;
    assign w_we    = w_accept ? ~WEB : '0;
    assign w_re    = w_accept && (WEB == WEB_READ);
  end else begin : g_wait
    logic [BYTES-1:0]  r_web;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic              w_commit;

    // Request is captured at acceptance; bus changes during the wait
    // therefore have no effect on the committed access.
    always_ff @(posedge clk) begin
      if (w_accept) begin
        r_web   <= WEB;
        r_addr  <= A;
        r_wdata <= DI;
      end
    end

    assign w_commit = (r_state == DM_WAIT) && (r_cnt == '0);
    assign w_addr   = r_addr;
    assign w_wdata  = r_wdata;
    assign w_we     = w_commit ? ~r_web : '0;
    assign w_re     = w_commit && (r_web == WEB_READ);
  end

  dm_byte_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we),
    .re    (w_re),
    .addr  (w_addr),
    .wdata (w_wdata),
    .rdata (DO)
  );

  assign DM_stall = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`timescale 1ns/1ps
module tb_dm_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance with zero wait states
  logic        cs0;
  logic [3:0]  web0;
  logic [13:0] a0;
  logic [31:0] di0, do0;
  logic        st0;

  // Instance with three wait states
  logic        cs3;
  logic [3:0]  web3;
  logic [13:0] a3;
  logic [31:0] di3, do3;
  logic        st3;

  dm_responder #(.ADDR_W(14), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .CS(cs0), .WEB(web0), .A(a0), .DI(di0),
    .DO(do0), .DM_stall(st0)
  );

  dm_responder #(.ADDR_W(14), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .CS(cs3), .WEB(web3), .A(a3), .DI(di3),
    .DO(do3), .DM_stall(st3)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: word contents per address plus the expected DO
  logic [31:0] mdl0 [int];
  logic [31:0] mdl3 [int];
  logic [31:0] exp0, exp3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] web,
                                        input logic [31:0] di);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (!web[b]) r[8*b +: 8] = di[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd_mdl0(input int a);
    return mdl0.exists(a) ? mdl0[a] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] rd_mdl3(input int a);
    return mdl3.exists(a) ? mdl3[a] : 32'hxxxx_xxxx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle access on the zero-wait instance, then check DO and stall.
  task automatic acc0(input string tag, input logic cs, input logic [3:0] web,
                      input logic [13:0] a, input logic [31:0] di);
    cs0 = cs; web0 = web; a0 = a; di0 = di;
    tick();
    if (cs) begin
      if (web == 4'hF) exp0 = rd_mdl0(int'(a));
      else mdl0[int'(a)] = merge(mdl0.exists(int'(a)) ? mdl0[int'(a)] : 32'h0, web, di);
    end
    cs0 = 1'b0;
    check({tag, "_do"}, do0, exp0);
    check({tag, "_stall"}, {31'b0, st0}, 32'h0);
  endtask

  // Access on the three-wait instance; the bus is scrambled (A=9) during
  // the wait and the stall length is measured with a bounded loop.
  task automatic acc3(input string tag, input logic [3:0] web,
                      input logic [13:0] a, input logic [31:0] di);
    int cnt;
    logic [31:0] old_do;
    cs3 = 1'b1; web3 = web; a3 = a; di3 = di;
    tick();
    check({tag, "_stall_on"}, {31'b0, st3}, 32'h1);
    old_do = exp3;
    cnt = 0;
    while (st3 === 1'b1 && cnt < 10) begin
      check({tag, "_do_wait"}, do3, old_do);
      if (cnt == 0) begin
        a3   = 14'd9;
        web3 = 4'($urandom_range(0, 15));
        di3  = $urandom;
      end
      tick();
      cnt++;
    end
    cs3 = 1'b0;
    check({tag, "_stall_len"}, 32'(cnt), 32'd3);
    if (web == 4'hF) exp3 = rd_mdl3(int'(a));
    else mdl3[int'(a)] = merge(mdl3.exists(int'(a)) ? mdl3[int'(a)] : 32'h0, web, di);
    check({tag, "_do"}, do3, exp3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [13:0] addrs [64];
    logic        is_rd;
    logic        cs;

    rst = 1'b0;
    cs0 = 0; web0 = 4'hF; a0 = '0; di0 = '0;
    cs3 = 0; web3 = 4'hF; a3 = '0; di3 = '0;
    exp0 = 32'h0;
    exp3 = 32'h0;
    tick();
    tick();
    check("rst_do0", do0, 32'h0);
    check("rst_st0", {31'b0, st0}, 32'h0);
    check("rst_do3", do3, 32'h0);
    check("rst_st3", {31'b0, st3}, 32'h0);
    rst = 1'b1;
    tick();

    // Zero-wait directed sequence
    acc0("w5_full", 1'b1, 4'b0000, 14'd5, 32'hDEADBEEF);
    acc0("r5_a",    1'b1, 4'b1111, 14'd5, 32'h0);
    check("r5_a_val", do0, 32'hDEADBEEF);
    acc0("w5_b0",   1'b1, 4'b1110, 14'd5, 32'h000000AA);
    acc0("r5_b",    1'b1, 4'b1111, 14'd5, 32'h0);
    check("r5_b_val", do0, 32'hDEADBEAA);
    acc0("w9",      1'b1, 4'b0000, 14'd9, 32'h00000001);
    check("w9_do_hold", do0, 32'hDEADBEAA);
    acc0("idle",    1'b0, 4'b1111, 14'd9, 32'h0);
    acc0("r9",      1'b1, 4'b1111, 14'd9, 32'h0);
    check("r9_val", do0, 32'h00000001);

    // Three-wait directed sequence
    acc3("w3_5_full", 4'b0000, 14'd5, 32'hDEADBEEF);
    acc3("w3_5_b0",   4'b1110, 14'd5, 32'h000000AA);
    acc3("r3_5",      4'b1111, 14'd5, 32'h0);
    check("r3_5_val", do3, 32'hDEADBEAA);
    acc3("w3_7_pre",  4'b0000, 14'd7, 32'hA5A50F0F);

    // Reset one cycle after a write is accepted in the wait states
    cs3 = 1'b1; web3 = 4'b0000; a3 = 14'd7; di3 = 32'h12345678;
    tick();
    check("rw_stall_on", {31'b0, st3}, 32'h1);
    tick();
    cs0 = 1'b1; web0 = 4'b0000; a0 = 14'd5; di0 = 32'hFFFFFFFF;
    #2 rst = 1'b0;
    #1;
    exp0 = 32'h0;
    exp3 = 32'h0;
    check("rw_do3", do3, 32'h0);
    check("rw_st3", {31'b0, st3}, 32'h0);
    check("rw_do0", do0, 32'h0);
    tick();
    tick();
    cs3 = 1'b0;
    cs0 = 1'b0;
    rst = 1'b1;
    acc3("rw_r7", 4'b1111, 14'd7, 32'h0);
    check("rw_r7_val", do3, 32'hA5A50F0F);
    acc0("rw_r5", 1'b1, 4'b1111, 14'd5, 32'h0);
    check("rw_r5_val", do0, 32'hDEADBEAA);

    // Randomized zero-wait traffic over 64 addresses
    for (int i = 0; i < 64; i++) begin
      addrs[i] = 14'($urandom_range(0, 16383));
      acc0("fill", 1'b1, 4'b0000, addrs[i], $urandom);
    end
    is_rd = 1'b1;
    for (int c = 0; c < 128; c++) begin
      cs = 1'($urandom_range(0, 1));
      if (is_rd)
        acc0("rnd_rd", cs, 4'b1111, addrs[$urandom_range(0, 63)], $urandom);
      else
        acc0("rnd_wr", cs, 4'($urandom_range(0, 14)), addrs[$urandom_range(0, 63)], $urandom);
      is_rd = ~is_rd;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
